// File: rtl/timer_mmio.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : timer_mmio                                                     |
// | Function : memory-mapped 64-bit machine timer with prescaler and irq      |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module timer_mmio #(
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] PRESCALE_RST = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic [ADDR_W-1:0] address,
  input  logic              w_en,
  input  logic [31:0]       write_data,
  input  logic [3:0]        masking,
  output logic [31:0]       read_data,
  output logic              valid,
  output logic              irq
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  localparam logic [ADDR_W-1:0] A_MTIME_LO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_MTIME_HI = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CMP_LO   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CMP_HI   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(6);

  logic [0:0]  state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pending_q, pending_d;
  logic [31:0] prescale_q, prescale_d;
  logic [31:0] presc_cnt_q, presc_cnt_d;
  logic [31:0] read_data_q, read_data_d;
  logic        irq_q, irq_d;
  logic [31:0] rmux;

  logic accept, wr, wr_mtime, tick, w1c;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  assign accept   = (state_q == S_IDLE) && request;
  assign wr       = accept && w_en;
  assign wr_mtime = wr && (|masking) &&
                    ((address == A_MTIME_LO) || (address == A_MTIME_HI));
  assign tick     = ctrl_q[0] && (presc_cnt_q == prescale_q);
  assign w1c      = wr && (address == A_STATUS) && masking[0] && write_data[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (request) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid = (state_q == S_RESP);
  end

  always_comb begin
    rmux = '0;
    case (address)
      A_MTIME_LO: rmux = mtime_q[31:0];
      A_MTIME_HI: rmux = mtime_q[63:32];
      A_CMP_LO:   rmux = cmp_q[31:0];
      A_CMP_HI:   rmux = cmp_q[63:32];
      A_CTRL:     rmux = {30'd0, ctrl_q};
      A_STATUS:   rmux = {31'd0, pending_q};
      A_PRESCALE: rmux = prescale_q;
      default:    rmux = '0;
    endcase
  end

  always_comb begin
    read_data_d = (accept && !w_en) ? rmux : read_data_q;

    presc_cnt_d = presc_cnt_q;
    if (ctrl_q[0]) presc_cnt_d = tick ? 32'd0 : presc_cnt_q + 32'd1;
    prescale_d = prescale_q;
    if (wr && (address == A_PRESCALE)) begin
      prescale_d  = merge(prescale_q, write_data, masking);
      presc_cnt_d = 32'd0;
    end

    // A software write to MTIME swallows the tick of that cycle entirely.
    mtime_d = mtime_q;
    if (wr_mtime) begin
      if (address == A_MTIME_LO) mtime_d[31:0]  = merge(mtime_q[31:0], write_data, masking);
      if (address == A_MTIME_HI) mtime_d[63:32] = merge(mtime_q[63:32], write_data, masking);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    cmp_d = cmp_q;
    if (wr && (address == A_CMP_LO)) cmp_d[31:0]  = merge(cmp_q[31:0], write_data, masking);
    if (wr && (address == A_CMP_HI)) cmp_d[63:32] = merge(cmp_q[63:32], write_data, masking);

    ctrl_d = ctrl_q;
    if (wr && (address == A_CTRL) && masking[0]) ctrl_d = write_data[1:0];

    pending_d = (mtime_q >= cmp_q) | (pending_q & ~w1c);
    irq_d     = pending_d & ctrl_d[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q     <= 64'd0;
      cmp_q       <= {64{1'b1}};
      ctrl_q      <= 2'd0;
      pending_q   <= 1'b0;
      prescale_q  <= PRESCALE_RST;
      presc_cnt_q <= 32'd0;
      read_data_q <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      cmp_q       <= cmp_d;
      ctrl_q      <= ctrl_d;
      pending_q   <= pending_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      read_data_q <= read_data_d;
      irq_q       <= irq_d;
    end
  end

  assign read_data = read_data_q;
  assign irq       = irq_q;

endmodule
`default_nettype wire

// File: doc/timer_mmio.md
TIMER_MMIO -- requirements
Module: timer_mmio

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width; matches the data-memory address port.
REQ-002 Parameter PRESCALE_RST, default 0, reset value of the PRESCALE register.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low; the block is held in reset while rst=0.
REQ-005 request  input  1  initiator access strobe.
REQ-006 address  input  ADDR_W  word address; byte offset already stripped by the initiator.
REQ-007 w_en  input  1  1=write, 0=read.
REQ-008 write_data  input  32  store data.
REQ-009 masking  input  4  byte enables; bit i gates write_data[8i+7:8i].
REQ-010 read_data  output  32  registered response data.
REQ-011 valid  output  1  one-cycle response strobe.
REQ-012 irq  output  1  timer interrupt, level, registered.

Function
REQ-013 Register map (word address): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 EN, bit1 IRQ_EN, others read 0), 5 STATUS (bit0 PENDING, W1C), 6 PRESCALE (32-bit).
REQ-014 Handshake FSM, two states: IDLE, RESP.
REQ-015 IDLE with request=1: accept, go to RESP; IDLE with request=0: stay.
REQ-016 RESP: valid=1 for exactly that cycle, unconditional return to IDLE; request in RESP is ignored (no second accept).
REQ-017 Latency: valid rises the cycle after acceptance; back-to-back accepts are possible every 2 cycles.
REQ-018 Read: read_data captured at acceptance from pre-edge register values; held until the next accepted read.
REQ-019 Write: applied at the acceptance edge, byte-wise per masking; masking=4'b0000 changes nothing but still returns valid.
REQ-020 Write acceptance does not modify read_data.
REQ-021 Unmapped addresses (7 and above): reads return 0, writes are ignored, valid is still returned.
REQ-022 Prescaler: a 32-bit counter increments each cycle while EN=1. When it equals PRESCALE, it clears and MTIME increments by 1.
REQ-023 PRESCALE=0 therefore advances MTIME every cycle while EN=1.
REQ-024 EN=0: prescaler and MTIME hold their values.
REQ-025 MTIME is 64-bit unsigned; carry from LO into HI occurs in the same cycle; 2^64-1 wraps to 0.
REQ-026 A software write to any MTIME byte in the same cycle as a tick: written bytes take the write value, and the whole tick is discarded that cycle.
REQ-027 PENDING sets on any cycle where MTIME >= MTIMECMP (64-bit unsigned compare on registered values).
REQ-028 Writing 1 to STATUS bit0 clears PENDING; if the set condition holds in the same cycle, set wins.
REQ-029 irq is registered as PENDING & IRQ_EN, updated every cycle, and is independent of the handshake.
REQ-030 Writes to PRESCALE also clear the prescaler counter.

Reset
REQ-031 rst=0: state=IDLE, valid=0, read_data=0, irq=0, MTIME=0, MTIMECMP=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PENDING=0, PRESCALE=PRESCALE_RST, prescaler=0.
REQ-032 Reset mid-access (in RESP) drops the response: no valid after rst returns high.
REQ-033 The first accept is possible on the first rising edge with rst=1.

Verification
REQ-034 Reset release, read addr 4: valid exactly 1 cycle after request, read_data=0; read addr 3 gives 32'hFFFF_FFFF.
REQ-035 Write PRESCALE=3, CTRL=1, wait 16 cycles: MTIME_LO advances by 4 (±1 for access timing), and each read has 1-cycle valid latency.
REQ-036 Write MTIME_LO=32'hFFFF_FFFF, MTIME_HI=0, PRESCALE=0, EN=1: within 2 cycles read MTIME_HI=1 and MTIME_LO small (carry check).
REQ-037 MTIMECMP=10, CTRL=3, PRESCALE=0: irq rises the cycle after MTIME reaches 10; W1C to STATUS leaves irq high (set wins); then MTIMECMP=all-ones, W1C clears it and irq falls.
REQ-038 Write addr 2 with masking=4'b0010, write_data=32'hAABBCCDD: MTIMECMP_LO=32'hFFFFCCFF; write addr 9 returns valid and changes nothing.
REQ-039 Request held high for 4 cycles: exactly 2 valid pulses. Assert rst=0 during RESP: no valid, all registers return to their reset values.
